// File: rtl/peripheral_dbg_pu_riscv_jsp_apb4_poller_if.sv
// APB4 bus between the JSP poller (master) and the JSP BIU (slave).
interface peripheral_dbg_pu_riscv_jsp_apb4_poller_if;
   logic       PSEL;
   logic       PENABLE;
   logic       PWRITE;
   logic [2:0] PADDR;
   logic [7:0] PWDATA;
   logic [7:0] PRDATA;
   logic       PREADY;
   logic       PSLVERR;

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/peripheral_dbg_pu_riscv_jsp_apb4_poller.sv
// APB4 master that polls the JSP BIU LSR and moves bytes to/from rx/tx streams.
// Define JSP_POLLER_INT_EN to poll only on int_i, tx request or rx drain (gap then only rate-limits).
module peripheral_dbg_pu_riscv_jsp_apb4_poller #(
   parameter int unsigned POLL_GAP = 4
) (
   input  logic                                             PCLK,
   input  logic                                             PRESETn,
   peripheral_dbg_pu_riscv_jsp_apb4_poller_if.master        apb,
   input  logic                                             int_i,
   output logic [7:0]                                       rx_data_o,
   output logic                                             rx_valid_o,
   input  logic                                             rx_ready_i,
   input  logic [7:0]                                       tx_data_i,
   input  logic                                             tx_valid_i,
   output logic                                             tx_ready_o,
   output logic                                             err_o
);
   localparam int unsigned     CNT_W     = 8;
   localparam int unsigned     DATA_W    = 8;
   localparam logic [CNT_W-1:0] GAP_INIT = CNT_W'(POLL_GAP);
   localparam logic [2:0]      ADDR_DATA = 3'h0;
   localparam logic [2:0]      ADDR_LSR  = 3'h5;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LSR_S = 3'd1,
      LSR_A = 3'd2,
      RD_S  = 3'd3,
      RD_A  = 3'd4,
      WR_S  = 3'd5,
      WR_A  = 3'd6
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                psel_q, psel_d;
   logic                penable_q, penable_d;
   logic                pwrite_q, pwrite_d;
   logic [2:0]          paddr_q, paddr_d;
   logic [DATA_W-1:0]   pwdata_q, pwdata_d;
   logic [DATA_W-1:0]   rx_data_q, rx_data_d;
   logic                rx_valid_q, rx_valid_d;
   logic                err_q, err_d;
   logic                drain;
   logic                poll_go;

   assign drain = rx_valid_q && rx_ready_i;

`ifdef JSP_POLLER_INT_EN
   logic drained_q, drained_d;

   // Event-driven polling; the gap counter only enforces a minimum spacing.
   assign poll_go = (cnt_q <= CNT_W'(1)) && (int_i || tx_valid_i || drained_q);

   always_comb begin
      drained_d = drained_q;
      if (drain)
         drained_d = 1'b1;
      else if ((state_q == IDLE) && poll_go)
         drained_d = 1'b0;
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) drained_q <= 1'b0;
      else          drained_q <= drained_d;
   end
`else
   logic unused_int;
   assign unused_int = int_i;

   assign poll_go = tx_valid_i || (cnt_q <= CNT_W'(1));
`endif

   // Next state, counter, buffers; bus outputs are registered from the next state.
   always_comb begin
      state_d    = state_q;
      cnt_d      = GAP_INIT;
      pwdata_d   = pwdata_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = rx_valid_q;
      err_d      = 1'b0;
      tx_ready_o = 1'b0;

      if (drain)
         rx_valid_d = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d = (cnt_q > CNT_W'(1)) ? cnt_q - CNT_W'(1) : cnt_q;
            if (poll_go) begin
               state_d = LSR_S;
               cnt_d   = GAP_INIT;
            end
         end
         LSR_S: state_d = LSR_A;
         LSR_A: begin
            if (apb.PREADY) begin
               if (apb.PSLVERR) begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end else if (apb.PRDATA[0] && !rx_valid_q) begin
                  state_d = RD_S;
               end else if (apb.PRDATA[5] && tx_valid_i) begin
                  state_d  = WR_S;
                  pwdata_d = tx_data_i;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         RD_S: state_d = RD_A;
         RD_A: begin
            if (apb.PREADY) begin
               state_d = IDLE;
               if (apb.PSLVERR) begin
                  err_d = 1'b1;
               end else begin
                  rx_data_d  = apb.PRDATA;
                  rx_valid_d = 1'b1;
               end
            end
         end
         WR_S: state_d = WR_A;
         WR_A: begin
            if (apb.PREADY) begin
               state_d = IDLE;
               if (apb.PSLVERR) err_d      = 1'b1;
               else             tx_ready_o = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      psel_d    = (state_d != IDLE);
      penable_d = (state_d inside {LSR_A, RD_A, WR_A});
      pwrite_d  = (state_d inside {WR_S, WR_A});
      paddr_d   = (state_d inside {LSR_S, LSR_A}) ? ADDR_LSR : ADDR_DATA;
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q    <= IDLE;
         cnt_q      <= GAP_INIT;
         psel_q     <= 1'b0;
         penable_q  <= 1'b0;
         pwrite_q   <= 1'b0;
         paddr_q    <= 3'h0;
         pwdata_q   <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         psel_q     <= psel_d;
         penable_q  <= penable_d;
         pwrite_q   <= pwrite_d;
         paddr_q    <= paddr_d;
         pwdata_q   <= pwdata_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         err_q      <= err_d;
      end
   end

   assign apb.PSEL    = psel_q;
   assign apb.PENABLE = penable_q;
   assign apb.PWRITE  = pwrite_q;
   assign apb.PADDR   = paddr_q;
   assign apb.PWDATA  = pwdata_q;
   assign rx_data_o   = rx_data_q;
   assign rx_valid_o  = rx_valid_q;
   assign err_o       = err_q;
endmodule
